axil_reg_bank: RTL and testbench
================================

Name: axil_reg_bank

Overview:
- Parametrised AXI4-Lite slave register bank with NUM_REGS registers of DATA_WIDTH bits at BASE_ADDR.
- Successor to the single-register JTAG-to-AXI-Lite capture slave. Adds byte strobes, independent AW/W acceptance, address decode with SLVERR, per-register write pulses and per-register readback.
- Sits between the JTAG-to-AXI master and the DAC datapath/control logic.

Parameters:
DATA_WIDTH  32  register and bus data width; 32 or 64 only
ADDR_WIDTH  32  AXI address width
NUM_REGS    8   number of registers, 1..256
BASE_ADDR   0   byte address of register 0; aligned to DATA_WIDTH/8

Ports:
s_axi_aclk     in   1                    clock
s_axi_aresetn  in   1                    asynchronous active-low reset
s_axi_awaddr   in   ADDR_WIDTH           write address
s_axi_awvalid  in   1                    write address valid
s_axi_awready  out  1                    write address ready
s_axi_wdata    in   DATA_WIDTH           write data
s_axi_wstrb    in   DATA_WIDTH/8         byte strobes
s_axi_wvalid   in   1                    write data valid
s_axi_wready   out  1                    write data ready
s_axi_bresp    out  2                    write response
s_axi_bvalid   out  1                    write response valid
s_axi_bready   in   1                    write response ready
s_axi_araddr   in   ADDR_WIDTH           read address
s_axi_arvalid  in   1                    read address valid
s_axi_arready  out  1                    read address ready
s_axi_rdata    out  DATA_WIDTH           read data
s_axi_rresp    out  2                    read response
s_axi_rvalid   out  1                    read data valid
s_axi_rready   in   1                    read data ready
reg_out        out  NUM_REGS*DATA_WIDTH  register contents; reg i at bits [i*DATA_WIDTH +: DATA_WIDTH]
wr_pulse       out  NUM_REGS             one-cycle pulse, bit i set when reg i is written

Behaviour:
- Reset: s_axi_aresetn low clears state asynchronously.
  - All ready/valid outputs 0; bresp, rresp, rdata 0.
  - All registers 0; wr_pulse 0.
  - Reset mid-transaction discards it; no B or R beat is issued for it.
- Decode, applied identically to write and read addresses:
  - off = addr - BASE_ADDR; idx = off >> log2(DATA_WIDTH/8); low byte-offset bits are ignored.
  - Hit when addr >= BASE_ADDR and idx < NUM_REGS; otherwise miss.
- Write address channel:
  - awready = 1 when no address is held and no B response is pending; registered, so it first rises one cycle after reset release.
  - On AW handshake, latch awaddr and drop awready.
- Write data channel:
  - wready follows the same rule with its own holding register; latch wdata/wstrb on handshake.
  - AW and W may arrive in either order or in the same cycle.
- Commit, in the cycle after both are held:
  - On hit, update only bytes with wstrb=1; set wr_pulse[idx] for exactly one cycle; bresp=OKAY (2'b00).
  - On miss, no register changes, no pulse; bresp=SLVERR (2'b10).
  - Set bvalid with the commit; release both holding registers.
  - wstrb=0 on a hit still pulses wr_pulse and returns OKAY.
- Write response:
  - bvalid stays high until bready; bresp is stable while bvalid is high.
  - awready/wready re-assert the cycle after the B handshake.
  - Minimum write cost: 3 cycles per transaction.
- Read channel:
  - arready = 1 when rvalid = 0 and no read is pending.
  - On AR handshake, drop arready; next cycle rvalid=1.
  - On hit, rdata = register value at the handshake edge; rresp=OKAY.
  - On miss, rdata=0; rresp=SLVERR.
  - rdata/rresp held until rready; arready re-asserts the cycle after the R handshake.
- Read and write are fully independent. A read handshaking in the same cycle as a write commit to the same register returns the pre-write value.
- reg_out is registered and updates the cycle after commit.

Test Plan:
1. Write 0xDEADBEEF, strb 0xF, to BASE_ADDR+4, with AW and W in the same cycle -> bresp=00; wr_pulse[1] for 1 cycle; reg_out reg1=0xDEADBEEF; read BASE_ADDR+4 returns 0xDEADBEEF, rresp=00.
2. W presented 3 cycles before AW to reg0, data 0x11223344, strb 0x5 (reg0 previously 0xFFFFFFFF) -> reg0=0xFF22FF44; exactly one B beat.
3. Write and read to BASE_ADDR + 4*NUM_REGS -> bresp=10 and rresp=10, rdata=0; no wr_pulse; all registers unchanged.
4. Hold bready=0 for 5 cycles after a write -> bvalid/bresp stable; awready=wready=0 throughout; next write accepted only after the B handshake.
5. Hold rready low for 4 cycles -> rdata stable; arready=0. Separately, issue a read in the same cycle as a write commit to the same register -> the read returns the old value.
6. Assert reset with a held AW (no W yet) -> all outputs and registers 0; after release, a fresh write completes normally with a single B beat.

Source files
------------

// File: rtl/axil_reg_bank.sv
// AXI4-Lite slave register bank: byte-strobed writes, address decode with
// SLVERR on miss, one-cycle per-register write pulses and flat readback bus.
module axil_reg_bank #(
    parameter int unsigned           DATA_WIDTH = 32,
    parameter int unsigned           ADDR_WIDTH = 32,
    parameter int unsigned           NUM_REGS   = 8,
    parameter logic [ADDR_WIDTH-1:0] BASE_ADDR  = '0
) (
    input  logic                           s_axi_aclk,
    input  logic                           s_axi_aresetn,
    input  logic [ADDR_WIDTH-1:0]          s_axi_awaddr,
    input  logic                           s_axi_awvalid,
    output logic                           s_axi_awready,
    input  logic [DATA_WIDTH-1:0]          s_axi_wdata,
    input  logic [DATA_WIDTH/8-1:0]        s_axi_wstrb,
    input  logic                           s_axi_wvalid,
    output logic                           s_axi_wready,
    output logic [1:0]                     s_axi_bresp,
    output logic                           s_axi_bvalid,
    input  logic                           s_axi_bready,
    input  logic [ADDR_WIDTH-1:0]          s_axi_araddr,
    input  logic                           s_axi_arvalid,
    output logic                           s_axi_arready,
    output logic [DATA_WIDTH-1:0]          s_axi_rdata,
    output logic [1:0]                     s_axi_rresp,
    output logic                           s_axi_rvalid,
    input  logic                           s_axi_rready,
    output logic [NUM_REGS*DATA_WIDTH-1:0] reg_out,
    output logic [NUM_REGS-1:0]            wr_pulse
);

    localparam int unsigned STRB_W      = DATA_WIDTH / 8;
    localparam int unsigned SHIFT       = $clog2(STRB_W);
    localparam logic [1:0]  RESP_OKAY   = 2'b00;
    localparam logic [1:0]  RESP_SLVERR = 2'b10;

    logic [DATA_WIDTH-1:0] regs_q [NUM_REGS];
    logic [DATA_WIDTH-1:0] regs_d [NUM_REGS];

    logic                  aw_held_q, aw_held_d;
    logic [ADDR_WIDTH-1:0] awaddr_q, awaddr_d;
    logic                  w_held_q, w_held_d;
    logic [DATA_WIDTH-1:0] wdata_q, wdata_d;
    logic [STRB_W-1:0]     wstrb_q, wstrb_d;
    logic                  awready_q, awready_d;
    logic                  wready_q, wready_d;
    logic                  bvalid_q, bvalid_d;
    logic [1:0]            bresp_q, bresp_d;
    logic [NUM_REGS-1:0]   wr_pulse_q, wr_pulse_d;

    logic                  arready_q, arready_d;
    logic                  rvalid_q, rvalid_d;
    logic [DATA_WIDTH-1:0] rdata_q, rdata_d;
    logic [1:0]            rresp_q, rresp_d;

    // Index is kept at full address width so out-of-range offsets never alias.
    function automatic logic [ADDR_WIDTH-1:0] decode_idx(input logic [ADDR_WIDTH-1:0] addr);
        logic [ADDR_WIDTH-1:0] off;
        off = addr - BASE_ADDR;
        return off >> SHIFT;
    endfunction

    function automatic logic decode_hit(input logic [ADDR_WIDTH-1:0] addr);
        return (addr >= BASE_ADDR) && (decode_idx(addr) < ADDR_WIDTH'(NUM_REGS));
    endfunction

    logic                  commit;
    logic                  aw_hit;
    logic [ADDR_WIDTH-1:0] aw_idx;
    logic                  ar_hs;
    logic                  ar_hit;
    logic [ADDR_WIDTH-1:0] ar_idx;

    assign commit = aw_held_q && w_held_q;
    assign aw_hit = decode_hit(awaddr_q);
    assign aw_idx = decode_idx(awaddr_q);
    assign ar_hs  = s_axi_arvalid && arready_q;
    assign ar_hit = decode_hit(s_axi_araddr);
    assign ar_idx = decode_idx(s_axi_araddr);

    always_comb begin
        aw_held_d  = aw_held_q;
        awaddr_d   = awaddr_q;
        w_held_d   = w_held_q;
        wdata_d    = wdata_q;
        wstrb_d    = wstrb_q;
        bvalid_d   = bvalid_q;
        bresp_d    = bresp_q;
        wr_pulse_d = '0;
        regs_d     = regs_q;

        if (s_axi_awvalid && awready_q) begin
            aw_held_d = 1'b1;
            awaddr_d  = s_axi_awaddr;
        end
        if (s_axi_wvalid && wready_q) begin
            w_held_d = 1'b1;
            wdata_d  = s_axi_wdata;
            wstrb_d  = s_axi_wstrb;
        end

        // Readies are low while both are held, so no new handshake can race the commit.
        if (commit) begin
            aw_held_d = 1'b0;
            w_held_d  = 1'b0;
            bvalid_d  = 1'b1;
            bresp_d   = aw_hit ? RESP_OKAY : RESP_SLVERR;
            for (int i = 0; i < NUM_REGS; i++) begin
                if (aw_hit && aw_idx == ADDR_WIDTH'(i)) begin
                    wr_pulse_d[i] = 1'b1;
                    for (int b = 0; b < STRB_W; b++) begin
                        if (wstrb_q[b]) begin
                            regs_d[i][b*8 +: 8] = wdata_q[b*8 +: 8];
                        end
                    end
                end
            end
        end else if (bvalid_q && s_axi_bready) begin
            bvalid_d = 1'b0;
        end

        awready_d = !aw_held_d && !bvalid_d;
        wready_d  = !w_held_d && !bvalid_d;
    end

    // Read data is captured from the pre-commit register state at the AR edge.
    always_comb begin
        rvalid_d = rvalid_q;
        rdata_d  = rdata_q;
        rresp_d  = rresp_q;

        if (ar_hs) begin
            rvalid_d = 1'b1;
            rdata_d  = '0;
            rresp_d  = ar_hit ? RESP_OKAY : RESP_SLVERR;
            for (int i = 0; i < NUM_REGS; i++) begin
                if (ar_hit && ar_idx == ADDR_WIDTH'(i)) begin
                    rdata_d = regs_q[i];
                end
            end
        end else if (rvalid_q && s_axi_rready) begin
            rvalid_d = 1'b0;
        end

        arready_d = !rvalid_d;
    end

    always_ff @(posedge s_axi_aclk or negedge s_axi_aresetn) begin
        if (!s_axi_aresetn) begin
            for (int i = 0; i < NUM_REGS; i++) begin
                regs_q[i] <= '0;
            end
            aw_held_q  <= 1'b0;
            awaddr_q   <= '0;
            w_held_q   <= 1'b0;
            wdata_q    <= '0;
            wstrb_q    <= '0;
            awready_q  <= 1'b0;
            wready_q   <= 1'b0;
            bvalid_q   <= 1'b0;
            bresp_q    <= 2'b00;
            wr_pulse_q <= '0;
            arready_q  <= 1'b0;
            rvalid_q   <= 1'b0;
            rdata_q    <= '0;
            rresp_q    <= 2'b00;
        end else begin
            regs_q     <= regs_d;
            aw_held_q  <= aw_held_d;
            awaddr_q   <= awaddr_d;
            w_held_q   <= w_held_d;
            wdata_q    <= wdata_d;
            wstrb_q    <= wstrb_d;
            awready_q  <= awready_d;
            wready_q   <= wready_d;
            bvalid_q   <= bvalid_d;
            bresp_q    <= bresp_d;
            wr_pulse_q <= wr_pulse_d;
            arready_q  <= arready_d;
            rvalid_q   <= rvalid_d;
            rdata_q    <= rdata_d;
            rresp_q    <= rresp_d;
        end
    end

    assign s_axi_awready = awready_q;
    assign s_axi_wready  = wready_q;
    assign s_axi_bvalid  = bvalid_q;
    assign s_axi_bresp   = bresp_q;
    assign s_axi_arready = arready_q;
    assign s_axi_rvalid  = rvalid_q;
    assign s_axi_rdata   = rdata_q;
    assign s_axi_rresp   = rresp_q;
    assign wr_pulse      = wr_pulse_q;

    for (genvar g = 0; g < NUM_REGS; g++) begin : g_reg_out
        assign reg_out[g*DATA_WIDTH +: DATA_WIDTH] = regs_q[g];
    end

endmodule

// File: tb/tb_axil_reg_bank.sv
// Self-checking bench for axil_reg_bank: directed AXI-Lite traffic checked
// every cycle against a transaction-level register model.
module tb_axil_reg_bank;

    localparam int          DW   = 32;
    localparam int          AW   = 32;
    localparam int          NR   = 8;
    localparam logic [31:0] BASE = 32'h0000_1000;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic [31:0]   awaddr = '0;
    logic          awvalid = 1'b0;
    logic          awready;
    logic [31:0]   wdata = '0;
    logic [3:0]    wstrb = '0;
    logic          wvalid = 1'b0;
    logic          wready;
    logic [1:0]    bresp;
    logic          bvalid;
    logic          bready = 1'b0;
    logic [31:0]   araddr = '0;
    logic          arvalid = 1'b0;
    logic          arready;
    logic [31:0]   rdata;
    logic [1:0]    rresp;
    logic          rvalid;
    logic          rready = 1'b0;
    logic [NR*DW-1:0] reg_out;
    logic [NR-1:0] wr_pulse;

    axil_reg_bank #(
        .DATA_WIDTH(DW), .ADDR_WIDTH(AW), .NUM_REGS(NR), .BASE_ADDR(BASE)
    ) dut (
        .s_axi_aclk(clk), .s_axi_aresetn(rst_n),
        .s_axi_awaddr(awaddr), .s_axi_awvalid(awvalid), .s_axi_awready(awready),
        .s_axi_wdata(wdata), .s_axi_wstrb(wstrb), .s_axi_wvalid(wvalid), .s_axi_wready(wready),
        .s_axi_bresp(bresp), .s_axi_bvalid(bvalid), .s_axi_bready(bready),
        .s_axi_araddr(araddr), .s_axi_arvalid(arvalid), .s_axi_arready(arready),
        .s_axi_rdata(rdata), .s_axi_rresp(rresp), .s_axi_rvalid(rvalid), .s_axi_rready(rready),
        .reg_out(reg_out), .wr_pulse(wr_pulse)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_errors = 0;
    int n_bbeats = 0;

    task automatic chk(input string name, input logic [255:0] act, input logic [255:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Model: register array plus queues of accepted AW/W/AR beats.
    logic [31:0] m_regs [NR];
    logic [31:0] q_aw [$];
    logic [31:0] q_wd [$];
    logic [3:0]  q_ws [$];
    logic [33:0] q_rd [$];

    function automatic bit m_hit(input logic [31:0] a);
        return (a >= BASE) && (((a - BASE) >> 2) < NR);
    endfunction

    function automatic int m_idx(input logic [31:0] a);
        return int'((a - BASE) >> 2);
    endfunction

    initial begin : compare
        logic [31:0]  c_a, c_d;
        logic [3:0]   c_s;
        logic [33:0]  c_r;
        logic [NR-1:0] pulse_exp;
        logic [255:0] m_pack;
        bit           b_hold, r_hold;
        logic [1:0]   bresp_prev, rresp_prev;
        logic [31:0]  rdata_prev;
        b_hold = 0;
        r_hold = 0;
        bresp_prev = '0;
        rresp_prev = '0;
        rdata_prev = '0;
        forever begin
            @(negedge clk);
            if (!rst_n) begin
                for (int i = 0; i < NR; i++) m_regs[i] = '0;
                q_aw.delete(); q_wd.delete(); q_ws.delete(); q_rd.delete();
                b_hold = 0;
                r_hold = 0;
                chk("rst_ready", 256'({awready, wready, arready}), 256'(0));
                chk("rst_valid", 256'({bvalid, rvalid}), 256'(0));
                chk("rst_resp_data", 256'({bresp, rresp, rdata}), 256'(0));
                chk("rst_regs", 256'(reg_out), 256'(0));
                chk("rst_pulse", 256'(wr_pulse), 256'(0));
            end else begin
                pulse_exp = '0;
                if (bvalid && !b_hold) begin
                    n_bbeats++;
                    chk("b_matches_write", 256'(q_aw.size() > 0 && q_wd.size() > 0), 256'(1));
                    if (q_aw.size() > 0 && q_wd.size() > 0) begin
                        c_a = q_aw.pop_front();
                        c_d = q_wd.pop_front();
                        c_s = q_ws.pop_front();
                        if (m_hit(c_a)) begin
                            for (int b = 0; b < 4; b++)
                                if (c_s[b]) m_regs[m_idx(c_a)][b*8 +: 8] = c_d[b*8 +: 8];
                            pulse_exp[m_idx(c_a)] = 1'b1;
                            chk("bresp", 256'(bresp), 256'(2'b00));
                        end else begin
                            chk("bresp", 256'(bresp), 256'(2'b10));
                        end
                    end
                end else if (bvalid) begin
                    chk("bresp_stable", 256'(bresp), 256'(bresp_prev));
                end
                if (b_hold) chk("bvalid_held", 256'(bvalid), 256'(1));
                if (bvalid) chk("ready_low_during_b", 256'({awready, wready}), 256'(0));
                for (int i = 0; i < NR; i++) m_pack[i*32 +: 32] = m_regs[i];
                chk("wr_pulse", 256'(wr_pulse), 256'(pulse_exp));
                chk("reg_out", 256'(reg_out), m_pack);

                if (rvalid && !r_hold) begin
                    chk("r_matches_ar", 256'(q_rd.size() > 0), 256'(1));
                    if (q_rd.size() > 0) begin
                        c_r = q_rd.pop_front();
                        chk("rdata", 256'(rdata), 256'(c_r[31:0]));
                        chk("rresp", 256'(rresp), 256'(c_r[33:32]));
                    end
                end else if (rvalid) begin
                    chk("rdata_stable", 256'({rresp, rdata}), 256'({rresp_prev, rdata_prev}));
                end
                if (r_hold) chk("rvalid_held", 256'(rvalid), 256'(1));
                if (rvalid) chk("arready_low_during_r", 256'(arready), 256'(0));

                if (awvalid && awready) q_aw.push_back(awaddr);
                if (wvalid && wready) begin
                    q_wd.push_back(wdata);
                    q_ws.push_back(wstrb);
                end
                if (arvalid && arready)
                    q_rd.push_back(m_hit(araddr) ? {2'b00, m_regs[m_idx(araddr)]} : {2'b10, 32'h0});

                b_hold = bvalid && !bready;
                r_hold = rvalid && !rready;
                bresp_prev = bresp;
                rresp_prev = rresp;
                rdata_prev = rdata;
            end
        end
    end

    task automatic axi_write(input logic [31:0] addr, input logic [31:0] data, input logic [3:0] strb,
                             input int aw_dly, input int w_dly, input int b_dly,
                             output logic [1:0] resp, output int b_stall);
        bit aw_done = 0, w_done = 0, b_done = 0, aw_hs, w_hs;
        int t = 0;
        resp = 2'bxx;
        b_stall = 0;
        while (!(aw_done && w_done) && t < 40) begin
            awaddr  = addr;
            wdata   = data;
            wstrb   = strb;
            awvalid = !aw_done && t >= aw_dly;
            wvalid  = !w_done && t >= w_dly;
            @(negedge clk);
            aw_hs = awvalid && awready;
            w_hs  = wvalid && wready;
            @(posedge clk); #1;
            aw_done |= aw_hs;
            w_done  |= w_hs;
            t++;
        end
        awvalid = 1'b0;
        wvalid  = 1'b0;
        chk("write_accepted", 256'(aw_done && w_done), 256'(1));
        t = 0;
        while (!b_done && t < 40) begin
            bready = (b_stall >= b_dly);
            @(negedge clk);
            if (bvalid) begin
                if (bready) begin
                    b_done = 1;
                    resp = bresp;
                end else begin
                    b_stall++;
                end
            end
            @(posedge clk); #1;
            t++;
        end
        bready = 1'b0;
        chk("write_b_done", 256'(b_done), 256'(1));
    endtask

    task automatic axi_read(input logic [31:0] addr, input int r_dly,
                            output logic [31:0] data, output logic [1:0] resp, output int r_stall);
        bit ar_done = 0, r_done = 0, ar_hs;
        int t = 0;
        data = 'x;
        resp = 2'bxx;
        r_stall = 0;
        while (!ar_done && t < 40) begin
            araddr  = addr;
            arvalid = 1'b1;
            @(negedge clk);
            ar_hs = arready;
            @(posedge clk); #1;
            ar_done = ar_hs;
            t++;
        end
        arvalid = 1'b0;
        chk("read_accepted", 256'(ar_done), 256'(1));
        t = 0;
        while (!r_done && t < 40) begin
            rready = (r_stall >= r_dly);
            @(negedge clk);
            if (rvalid) begin
                if (rready) begin
                    r_done = 1;
                    data = rdata;
                    resp = rresp;
                end else begin
                    r_stall++;
                end
            end
            @(posedge clk); #1;
            t++;
        end
        rready = 1'b0;
        chk("read_r_done", 256'(r_done), 256'(1));
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin : stim
        logic [1:0]  w_resp, r_resp;
        logic [31:0] rd;
        int          stall, stall2, beats0;
        bit          hs;

        repeat (3) @(negedge clk);
        @(posedge clk); #1;
        rst_n = 1'b1;
        @(negedge clk);
        chk("awready_before_first_edge", 256'(awready), 256'(0));
        @(negedge clk);
        chk("awready_rises", 256'({awready, wready}), 256'(2'b11));
        chk("arready_rises", 256'(arready), 256'(1));
        @(posedge clk); #1;

        // Same-cycle AW/W write, then readback.
        axi_write(BASE + 32'h4, 32'hDEAD_BEEF, 4'hF, 0, 0, 0, w_resp, stall);
        chk("t1_bresp", 256'(w_resp), 256'(2'b00));
        chk("t1_reg1", 256'(reg_out[63:32]), 256'(32'hDEAD_BEEF));
        axi_read(BASE + 32'h4, 0, rd, r_resp, stall);
        chk("t1_rdata", 256'(rd), 256'(32'hDEAD_BEEF));
        chk("t1_rresp", 256'(r_resp), 256'(2'b00));

        // W leads AW by three cycles, partial strobes.
        axi_write(BASE, 32'hFFFF_FFFF, 4'hF, 0, 0, 0, w_resp, stall);
        beats0 = n_bbeats;
        axi_write(BASE, 32'h1122_3344, 4'h5, 3, 0, 0, w_resp, stall);
        repeat (3) @(posedge clk); #1;
        chk("t2_one_beat", 256'(n_bbeats - beats0), 256'(1));
        chk("t2_reg0", 256'(reg_out[31:0]), 256'(32'hFF22_FF44));

        // Decode misses above and below the bank.
        axi_write(BASE + 32'h20, 32'hA5A5_A5A5, 4'hF, 0, 1, 0, w_resp, stall);
        chk("t3_bresp_miss", 256'(w_resp), 256'(2'b10));
        axi_read(BASE + 32'h20, 0, rd, r_resp, stall);
        chk("t3_rdata_miss", 256'(rd), 256'(0));
        chk("t3_rresp_miss", 256'(r_resp), 256'(2'b10));
        axi_read(BASE - 32'h4, 0, rd, r_resp, stall);
        chk("t3_rresp_below", 256'(r_resp), 256'(2'b10));
        chk("t3_reg1_kept", 256'(reg_out[63:32]), 256'(32'hDEAD_BEEF));

        // Zero strobes on a hit, and unaligned low address bits.
        axi_write(BASE + 32'hC, 32'h7777_7777, 4'h0, 0, 0, 0, w_resp, stall);
        chk("t3_zero_strb_okay", 256'(w_resp), 256'(2'b00));
        axi_write(BASE + 32'h16, 32'h5566_7788, 4'hF, 1, 0, 0, w_resp, stall);
        chk("t3_unaligned_reg5", 256'(reg_out[191:160]), 256'(32'h5566_7788));

        // B back-pressure.
        axi_write(BASE + 32'h8, 32'hCAFE_F00D, 4'hF, 0, 0, 5, w_resp, stall);
        chk("t4_b_stall", 256'(stall), 256'(5));
        chk("t4_bresp", 256'(w_resp), 256'(2'b00));
        chk("t4_reg2", 256'(reg_out[95:64]), 256'(32'hCAFE_F00D));

        // R back-pressure.
        axi_read(BASE + 32'h8, 4, rd, r_resp, stall);
        chk("t5_r_stall", 256'(stall), 256'(4));
        chk("t5_rdata", 256'(rd), 256'(32'hCAFE_F00D));

        // Read handshake on the commit edge of a write to the same register.
        fork
            axi_write(BASE + 32'h4, 32'h1234_5678, 4'hF, 0, 0, 0, w_resp, stall);
            begin
                @(posedge clk); #1;
                axi_read(BASE + 32'h4, 0, rd, r_resp, stall2);
            end
        join
        chk("t5_read_old_value", 256'(rd), 256'(32'hDEAD_BEEF));
        chk("t5_reg1_new", 256'(reg_out[63:32]), 256'(32'h1234_5678));

        // Reset while an AW is held without W.
        awaddr  = BASE + 32'h1C;
        awvalid = 1'b1;
        hs = 0;
        for (int t = 0; t < 10 && !hs; t++) begin
            @(negedge clk);
            hs = awready;
            @(posedge clk); #1;
        end
        awvalid = 1'b0;
        chk("t6_aw_held", 256'(hs), 256'(1));
        repeat (2) @(posedge clk);
        #3 rst_n = 1'b0;
        @(negedge clk);
        chk("t6_regs_cleared", 256'(reg_out), 256'(0));
        @(posedge clk); #1;
        rst_n = 1'b1;
        beats0 = n_bbeats;
        axi_write(BASE + 32'h1C, 32'h0BAD_C0DE, 4'hF, 0, 0, 0, w_resp, stall);
        repeat (3) @(posedge clk); #1;
        chk("t6_one_beat", 256'(n_bbeats - beats0), 256'(1));
        chk("t6_bresp", 256'(w_resp), 256'(2'b00));
        chk("t6_reg7", 256'(reg_out[255:224]), 256'(32'h0BAD_C0DE));
        chk("t6_reg0_zero", 256'(reg_out[31:0]), 256'(0));

        repeat (2) @(posedge clk);
        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
